// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, branch flush, multi-cycle wait, halt.
// Optional PIPE_CTRL_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipe_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       branch_taken,
    input  logic       mc_start,
    input  logic       mc_done,
    input  logic       halt,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic [1:0] state
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_MC_WAIT = 2'b01,
        S_HALT    = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   load_use;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        state_d     = state_q;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state       = state_q;
        case (state_q)
            S_RUN: begin
                if (halt) begin
                    state_d = S_HALT;
                end else if (mc_start) begin
                    if (!mc_done) state_d = S_MC_WAIT;
                end else if (branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            S_MC_WAIT: begin
                if (mc_done) begin
                    state_d = S_RUN;
                end else begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                end
            end
            S_HALT: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
            end
            default: state_d = S_RUN;
        endcase
        // Reset asserted: present the RUN defaults regardless of the held state.
        if (!reset) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            ex_mem_en   = 1'b1;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
            state       = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_RUN;
        else        state_q <= state_d;
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (!pc_en && (state_q != S_HALT) && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (if_id_flush && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes hand-computed expectations, a negedge monitor checks them.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, branch_taken, mc_start, mc_done, halt;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush;
    logic [1:0] state;
`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .mc_start     (mc_start),
        .mc_done      (mc_done),
        .halt         (halt),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .state        (state)
`ifdef PIPE_CTRL_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    // Expected vector: {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, state}
    localparam logic [7:0] RUN_DEF = 8'hF0;
    localparam logic [7:0] LU_STL  = 8'h34;
    localparam logic [7:0] BR_FLS  = 8'hFC;
    localparam logic [7:0] MC_STL  = 8'h01;
    localparam logic [7:0] MC_DONE = 8'hF1;
    localparam logic [7:0] HALTED  = 8'h02;

    typedef struct {
        string       nm;
        logic [7:0]  exp;
        logic        chk_cnt;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [7:0] act;
            e   = q.pop_front();
            act = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, state};
            n_chk++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: outputs got %b required %b", e.nm, act, e.exp);
            end
`ifdef PIPE_CTRL_PERF_CNT_EN
            if (e.chk_cnt) begin
                n_chk++;
                if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                    n_fail++;
                    $display("FAIL %s_cnt: stall/flush got %0d/%0d required %0d/%0d",
                             e.nm, stall_cnt, flush_cnt, e.sc, e.fc);
                end
            end
`endif
        end
    end

    task automatic cyc(input string nm, input logic r,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] ert,
                       input logic br, input logic ms, input logic md, input logic hl,
                       input logic [7:0] ex,
                       input logic ck = 1'b0, input logic [15:0] sc = 16'd0,
                       input logic [15:0] fc = 16'd0);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = r;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rt   = urt;
        ex_mem_read  = mr;
        ex_rt        = ert;
        branch_taken = br;
        mc_start     = ms;
        mc_done      = md;
        halt         = hl;
        e.nm      = nm;
        e.exp     = ex;
        e.chk_cnt = ck;
        e.sc      = sc;
        e.fc      = fc;
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_rt = '0; branch_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0; halt = 1'b0;

        //   name         rst rs     rt     urt mr ert    br ms md hl expected
        cyc("rst_def",    0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 0, 0, RUN_DEF);
        cyc("idle",       1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, RUN_DEF);
        cyc("lu_rs",      1, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, 0, LU_STL);
        cyc("lu_release", 1, 5'd5, 5'd0, 0, 0, 5'd5, 0, 0, 0, 0, RUN_DEF);
        cyc("zero_filt",  1, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 0, 0, RUN_DEF);
        cyc("rt_unused",  1, 5'd1, 5'd7, 0, 1, 5'd7, 0, 0, 0, 0, RUN_DEF);
        cyc("lu_rt",      1, 5'd1, 5'd7, 1, 1, 5'd7, 0, 0, 0, 0, LU_STL);
        cyc("br_over_lu", 1, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 0, 0, BR_FLS);
        cyc("br_only",    1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, BR_FLS);
        cyc("mc_c0",      1, 5'd5, 5'd0, 0, 1, 5'd5, 1, 1, 0, 0, RUN_DEF);
        cyc("mc_c1",      1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 1, MC_STL);
        cyc("mc_c2",      1, 5'd5, 5'd0, 0, 1, 5'd5, 0, 1, 0, 0, MC_STL);
        cyc("mc_c3",      1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, MC_STL);
        cyc("mc_c4",      1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, MC_DONE);
        cyc("mc_c5",      1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, RUN_DEF);
        cyc("mc_same",    1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, RUN_DEF);
        cyc("mc_same_n",  1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, RUN_DEF);
        cyc("mcr_c0",     1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, RUN_DEF);
        cyc("mcr_c1",     1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, MC_STL);
        cyc("mcr_rst",    0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, RUN_DEF, 1'b1, 16'd6, 16'd2);
        cyc("mcr_after",  1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, RUN_DEF, 1'b1, 16'd0, 16'd0);
        cyc("halt_mc",    1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, RUN_DEF);
        cyc("halt_1",     1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, HALTED);
        cyc("halt_2",     1, 5'd5, 5'd0, 0, 1, 5'd5, 1, 1, 1, 0, HALTED, 1'b1, 16'd0, 16'd0);
        cyc("halt_rst",   0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, RUN_DEF);
        cyc("halt_exit",  1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, RUN_DEF);
        cyc("halt_exit_lu", 1, 5'd9, 5'd0, 0, 1, 5'd9, 0, 0, 0, 0, LU_STL);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous active-low reset: clk and reset are the first two ports.
REQ-002 The block SHALL have these ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_rt  in  5  destination register of the load in EX.
- branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- mc_start  in  1  multi-cycle operation enters EX this cycle.
- mc_done  in  1  multi-cycle unit result ready.
- halt  in  1  halt instruction reached EX.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID latch enable.
- id_ex_en  out  1  ID/EX latch enable.
- ex_mem_en  out  1  EX/MEM latch enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load bubble (all control fields 0) into ID/EX.
- state  out  2  FSM state: 00 RUN, 01 MC_WAIT, 10 HALT.

Function
REQ-003 The FSM SHALL have exactly three states, RUN, MC_WAIT and HALT, with all transitions taken on the clk rising edge.
REQ-004 Outputs SHALL be Mealy: a function of the current state and the current-cycle inputs, with zero-cycle latency from hazard to enable/flush.
REQ-005 RUN defaults SHALL be: all four enables 1, both flushes 0.
REQ-006 Load-use in RUN SHALL be detected as ex_mem_read=1 AND ex_rt!=0 AND (ex_rt==id_rs OR (id_uses_rt AND ex_rt==id_rt)); on detection: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, for one cycle per detection.
REQ-007 branch_taken=1 in RUN SHALL assert if_id_flush=1 and id_ex_flush=1 for that cycle, with all enables at 1.
REQ-008 Priority in RUN SHALL be halt > mc_start > branch_taken > load-use; only the highest asserted event acts.
REQ-009 RUN with mc_start=1 and mc_done=0 SHALL go to MC_WAIT; mc_start=1 with mc_done=1 in the same cycle SHALL stay in RUN with no stall.
REQ-010 In MC_WAIT with mc_done=0, pc_en, if_id_en, id_ex_en and ex_mem_en SHALL all be 0, with both flushes 0.
REQ-011 In MC_WAIT, mc_done=1 SHALL drive all enables to 1 in that cycle and return to RUN; branch_taken, mc_start and load-use SHALL be ignored in MC_WAIT.
REQ-012 halt=1 in RUN SHALL go to HALT; from the next cycle all enables SHALL be 0 and both flushes 0.
REQ-013 HALT SHALL be exited only by reset; halt=1 while in MC_WAIT SHALL be ignored until RUN is reached.

Reset
REQ-014 reset=0 at a clk rising edge SHALL force state to RUN regardless of state or other inputs, including mid-MC_WAIT and HALT.
REQ-015 While reset=0, outputs SHALL equal the RUN defaults: all enables 1, flushes 0, state=00.
REQ-016 Counters present under REQ-017 SHALL clear to 0 on reset.

Configuration
REQ-017 With macro PIPE_CTRL_PERF_CNT_EN defined, the block SHALL add these outputs:
- stall_cnt  out  16  counts cycles with pc_en=0 while not in HALT.
- flush_cnt  out  16  counts cycles with if_id_flush=1.
- Both counters saturate at 0xFFFF.
REQ-018 Without PIPE_CTRL_PERF_CNT_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-019 Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 in RUN -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; next cycle, with ex_mem_read=0, defaults resume.
REQ-020 $zero filter and rt filter:
- ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall.
- ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall.
REQ-021 Multi-cycle: mc_start=1 at cycle 0, mc_done=1 at cycle 4:
- state=01 during cycles 1-4.
- All enables 0 in cycles 1-3.
- Enables 1 in cycle 4; state=00 in cycle 5.
REQ-022 Priority: branch_taken=1 together with a load-use match -> both flushes 1, pc_en=1; halt=1 with mc_start=1 -> state=10 next cycle.
REQ-023 Reset mid-MC_WAIT: reset=0 for one edge in cycle 2 of a wait -> state=00, all enables 1 on the following cycle, counters 0 when PIPE_CTRL_PERF_CNT_EN is defined.
